// File: rtl/mips_multicycle_controller.sv
// rtl/mips_multicycle_controller.sv - Moore control FSM for the MIPS multicycle datapath
module mips_multicycle_controller #(
    parameter int ALUCTL_W = 3,
    parameter int EN_BNE   = 1,
    parameter int EN_ORI   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pcen,
    output logic                irwrite,
    output logic                iord,
    output logic                memwrite,
    output logic                memtoreg,
    output logic                regdst,
    output logic                regwrite,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic [1:0]          pcsrc,
    output logic                immselect,
    output logic [ALUCTL_W-1:0] alucontrol,
    output logic                illegal_op,
    output logic [3:0]          state
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  RTEX   = 4'd6,  RTWB   = 4'd7,
        BEQEX  = 4'd8,  BNEEX  = 4'd9,  ADDIEX = 4'd10, ORIEX  = 4'd11,
        IWB    = 4'd12, JEX    = 4'd13
    } state_t;

    localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(3'b010);
    localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(3'b110);
    localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(3'b000);
    localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(3'b001);
    localparam logic [ALUCTL_W-1:0] ALU_SLT = ALUCTL_W'(3'b111);

    state_t cur, nxt;
    logic   imm_flag;
    logic   rt_ok;
    logic [ALUCTL_W-1:0] rt_alu;

    // imm_flag remembers which immediate form the last I-type EX used, so IWB can keep it stable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur      <= FETCH;
            imm_flag <= 1'b0;
        end else begin
            cur <= nxt;
            if (cur == ADDIEX)
                imm_flag <= 1'b0;
            else if (cur == ORIEX)
                imm_flag <= 1'b1;
        end
    end

    always_comb begin
        rt_ok  = 1'b1;
        rt_alu = ALU_ADD;
        case (funct)
            6'b100000: rt_alu = ALU_ADD;
            6'b100010: rt_alu = ALU_SUB;
            6'b100100: rt_alu = ALU_AND;
            6'b100101: rt_alu = ALU_OR;
            6'b101010: rt_alu = ALU_SLT;
            default:   rt_ok  = 1'b0;
        endcase
    end

    always_comb begin
        nxt        = cur;
        pcen       = 1'b0;
        irwrite    = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        immselect  = 1'b0;
        alucontrol = ALU_ADD;
        illegal_op = 1'b0;
        case (cur)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcen    = mem_ready;
                nxt     = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    6'b100011, 6'b101011: nxt = MEMADR;
                    6'b000000:            nxt = RTEX;
                    6'b000100:            nxt = BEQEX;
                    6'b001000:            nxt = ADDIEX;
                    6'b000010:            nxt = JEX;
                    6'b000101: begin
                        nxt        = (EN_BNE != 0) ? BNEEX : FETCH;
                        illegal_op = (EN_BNE == 0);
                    end
                    6'b001101: begin
                        nxt        = (EN_ORI != 0) ? ORIEX : FETCH;
                        illegal_op = (EN_ORI == 0);
                    end
                    default: begin
                        nxt        = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                nxt     = (op == 6'b100011) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord = 1'b1;
                nxt  = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                nxt      = FETCH;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                nxt      = mem_ready ? FETCH : MEMWR;
            end
            RTEX: begin
                alusrca    = 1'b1;
                alucontrol = rt_alu;
                illegal_op = ~rt_ok;
                nxt        = rt_ok ? RTWB : FETCH;
            end
            RTWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                nxt      = FETCH;
            end
            BEQEX, BNEEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = (cur == BEQEX) ? zero : ~zero;
                nxt        = FETCH;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                nxt     = IWB;
            end
            ORIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_OR;
                immselect  = 1'b1;
                nxt        = IWB;
            end
            IWB: begin
                regwrite  = 1'b1;
                immselect = imm_flag;
                nxt       = FETCH;
            end
            JEX: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
                nxt   = FETCH;
            end
            default: nxt = FETCH;
        endcase
    end

    assign state = cur;
endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
- Next-generation MIPS control unit for the multicycle datapath.
- Replaces the single-cycle op/funct decode with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles.
- Adds a memory-ready handshake and per-instruction enables for bne/ori.
- Sits between the instruction register and the shared ALU/memory datapath; drives every datapath mux and enable.

Parameters:
- ALUCTL_W, 3, width of alucontrol.
- EN_BNE, 1, 1 = bne decoded; 0 = opcode 000101 treated as illegal.
- EN_ORI, 1, 1 = ori decoded (zero-extended immediate); 0 = opcode 001101 treated as illegal.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces FETCH.
- op  in  6  instruction[31:26], from the instruction register.
- funct  in  6  instruction[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pcen  out  1  PC register enable.
- irwrite  out  1  instruction register load.
- iord  out  1  memory address: 0 = PC, 1 = ALUOut.
- memwrite  out  1  memory write strobe.
- memtoreg  out  1  register write data: 0 = ALUOut, 1 = Data.
- regdst  out  1  destination: 0 = rt, 1 = rd.
- regwrite  out  1  register file write.
- alusrca  out  1  ALU A: 0 = PC, 1 = rs.
- alusrcb  out  2  ALU B: 00 = rt, 01 = 4, 10 = imm, 11 = imm<<2.
- pcsrc  out  2  PC next: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- immselect  out  1  0 = sign-extend, 1 = zero-extend.
- alucontrol  out  ALUCTL_W  010 add, 110 sub, 000 and, 001 or, 111 slt.
- illegal_op  out  1  one-cycle pulse on an undecodable opcode.
- state  out  4  current state, for debug/verification.

Behaviour:
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - RTEX=6, RTWB=7, BEQEX=8, BNEEX=9, ADDIEX=10, ORIEX=11, IWB=12, JEX=13
- Control outputs are combinational from state only (Moore), except the zero and mem_ready gating listed below.
- Reset:
  - State is FETCH, asynchronously.
  - Outputs equal FETCH with mem_ready=0: alusrcb=01, alucontrol=010, all enables/strobes 0, pcsrc=00, iord=0.
  - Reset mid-instruction abandons it with no further writes.
- FETCH:
  - iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00.
  - irwrite=pcen=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE:
  - alusrca=0, alusrcb=11, add (branch target precompute).
  - Next state by op:
    - 100011 (lw) and 101011 (sw): MEMADR
    - 000000: RTEX
    - 000100: BEQEX
    - 000101: BNEEX if EN_BNE
    - 001000: ADDIEX
    - 001101: ORIEX if EN_ORI
    - 000010: JEX
  - Any other opcode: illegal_op=1 this cycle, next FETCH, no writes.
- MEMADR: alusrca=1, alusrcb=10, add. Next MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Holds until mem_ready; then MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0; next FETCH.
- MEMWR: iord=1, memwrite=1 every cycle until mem_ready. Exit to FETCH on mem_ready; the write is committed exactly once by memory.
- RTEX:
  - alusrca=1, alusrcb=00.
  - alucontrol from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Other funct: illegal_op=1, next FETCH, RTWB skipped.
- RTWB: regwrite=1, regdst=1, memtoreg=0; next FETCH.
- BEQEX: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero; next FETCH.
- BNEEX: same as BEQEX but pcen=~zero; next FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add, immselect=0; next IWB.
- ORIEX: alusrca=1, alusrcb=10, or, immselect=1; next IWB.
- IWB: regwrite=1, regdst=0, memtoreg=0. immselect is held at the previous EX value (registered flag); next FETCH.
- JEX: pcsrc=10, pcen=1; next FETCH.
- Latencies in cycles with mem_ready always 1: lw 5, sw 4, R-type 4, addi/ori 4, beq/bne 3, j 3.
- Each FETCH/MEMRD/MEMWR wait cycle adds one cycle.
- No output other than pcen/irwrite/illegal_op may depend on zero or mem_ready.

Test Plan:
- Reset asserted mid-MEMWR (state=5) -> state=0 immediately, memwrite=0, no further regwrite or pcen until the next FETCH with mem_ready.
- lw (op=100011), mem_ready=1 -> states 0,1,2,3,4; regwrite=1 and memtoreg=1 only in state 4; pcen only in cycle 0.
- R-type add (funct=100000) then slt (101010) -> RTEX alucontrol=010 then 111; regwrite=1 with regdst=1 in RTWB.
- beq with zero=1, then bne with zero=1 (EN_BNE=1) -> pcen=1 with pcsrc=01 in BEQEX; pcen=0 in BNEEX.
- ori (001101) -> ORIEX alucontrol=001, immselect=1 in ORIEX and IWB. With EN_ORI=0 -> illegal_op pulses in DECODE, next FETCH.
- sw with mem_ready low 3 cycles in MEMWR -> memwrite=1 for 4 cycles, exit to FETCH on the 4th, total latency 7; a FETCH stall of 2 cycles holds irwrite=0.
